// File: rtl/eth_rx_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// eth_rx_dispatch_pkg
// Shared types and constants for the Ethernet RX ethertype dispatcher and
// the ethertype matcher it uses.
//   dispatch_state_t : dispatcher FSM states (IDLE, HDR, PAYLOAD, DROP)
//   eth_type_t       : 16-bit ethertype value
//   ETH_TYPE_*       : well-known ethertype constants
// ---------------------------------------------------------------------------
package eth_rx_dispatch_pkg;

   typedef logic [15:0] eth_type_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2,
      DROP    = 2'd3
   } dispatch_state_t;

   localparam eth_type_t ETH_TYPE_IPV4 = 16'h0800;
   localparam eth_type_t ETH_TYPE_ARP  = 16'h0806;
   localparam eth_type_t ETH_TYPE_IPV6 = 16'h86DD;

endpackage

// File: rtl/AXIS_IF.sv
// ---------------------------------------------------------------------------
// AXIS_IF
// Minimal AXI-Stream bundle: data, valid, ready, last, user.
//   TDATA_WIDTH : width of tdata
//   TUSER_WIDTH : width of tuser
// ---------------------------------------------------------------------------
interface AXIS_IF #(
   parameter int TDATA_WIDTH = 8,
   parameter int TUSER_WIDTH = 1
);
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tvalid;
   logic                   tready;
   logic                   tlast;
   logic [TUSER_WIDTH-1:0] tuser;

   modport Sender   (output tdata, tvalid, tlast, tuser, input tready);
   modport Receiver (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ETH_HEADER_IF.sv
// ---------------------------------------------------------------------------
// ETH_HEADER_IF
// Parsed Ethernet header stream with a valid/ready handshake.
//   valid, ready          : handshake
//   dest_mac, src_mac     : 48-bit MAC addresses
//   eth_type              : 16-bit ethertype
// ---------------------------------------------------------------------------
interface ETH_HEADER_IF;
   logic        valid;
   logic        ready;
   logic [47:0] dest_mac;
   logic [47:0] src_mac;
   logic [15:0] eth_type;

   modport Sender   (output valid, dest_mac, src_mac, eth_type, input ready);
   modport Receiver (input valid, dest_mac, src_mac, eth_type, output ready);
endinterface

// File: rtl/eth_type_matcher.sv
// ---------------------------------------------------------------------------
// eth_type_matcher
// Combinational priority matcher: finds the lowest table index whose
// ethertype equals eth_type_i and whose enable bit is set.
//   eth_type_i    : ethertype to look up
//   port_enable_i : per-entry enable
//   hit_o         : an enabled entry matched
//   sel_o         : index of the lowest matching enabled entry (0 on miss)
// ---------------------------------------------------------------------------
module eth_type_matcher
   import eth_rx_dispatch_pkg::*;
#(
   parameter int        NUM_PORTS = 2,
   parameter int        SEL_W     = 1,
   parameter eth_type_t ETH_TYPE_MATCH [NUM_PORTS] = '{ETH_TYPE_ARP, ETH_TYPE_IPV4}
) (
   input  eth_type_t            eth_type_i,
   input  logic [NUM_PORTS-1:0] port_enable_i,
   output logic                 hit_o,
   output logic [SEL_W-1:0]     sel_o
);

   // Scan from the highest index down so that the last assignment made,
   // and therefore the one that sticks, is the lowest matching index.
   always_comb begin
      hit_o = 1'b0;
      sel_o = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_enable_i[i] && (eth_type_i == ETH_TYPE_MATCH[i])) begin
            hit_o = 1'b1;
            sel_o = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/eth_rx_type_dispatch.sv
// ---------------------------------------------------------------------------
// eth_rx_type_dispatch
// Steers each parsed Ethernet frame (header then payload) to one of
// NUM_PORTS consumers by ethertype. Unmatched or disabled frames are drained
// and counted.
//   clk, reset          : clock, synchronous active-low reset
//   eth_header_in_if    : parsed header input (valid/ready)
//   eth_payload_in_if   : 8-bit payload AXI-Stream input
//   port_enable         : per-port enable, sampled at header acceptance
//   out_hdr_valid/ready : per-port header handshake
//   out_dest_mac/src_mac/eth_type : registered header, shared by all ports
//   out_tdata/tlast/tuser : payload passthrough, shared by all ports
//   out_tvalid/tready   : per-port payload handshake
//   drop_count          : saturating count of dropped frames
//   error_count         : saturating count of forwarded frames ending tuser=1
//   busy                : FSM not idle
// Optional build macro ETH_RX_DISPATCH_STATS_EN adds port_frame_count, a
// saturating per-port count of forwarded frames.
// ---------------------------------------------------------------------------
module eth_rx_type_dispatch
   import eth_rx_dispatch_pkg::*;
#(
   parameter int        NUM_PORTS = 2,
   parameter eth_type_t ETH_TYPE_MATCH [NUM_PORTS] = '{ETH_TYPE_ARP, ETH_TYPE_IPV4},
   parameter int        CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   ETH_HEADER_IF.Receiver       eth_header_in_if,
   AXIS_IF.Receiver             eth_payload_in_if,
   input  logic [NUM_PORTS-1:0] port_enable,
   output logic [NUM_PORTS-1:0] out_hdr_valid,
   input  logic [NUM_PORTS-1:0] out_hdr_ready,
   output logic [47:0]          out_dest_mac,
   output logic [47:0]          out_src_mac,
   output logic [15:0]          out_eth_type,
   output logic [7:0]           out_tdata,
   output logic [NUM_PORTS-1:0] out_tvalid,
   input  logic [NUM_PORTS-1:0] out_tready,
   output logic                 out_tlast,
   output logic                 out_tuser,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic [CNT_WIDTH-1:0] error_count,
   output logic                 busy
`ifdef ETH_RX_DISPATCH_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] port_frame_count [NUM_PORTS]
`endif
);

   localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   dispatch_state_t      state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [NUM_PORTS-1:0] hdrValid_q, hdrValid_d;
   logic [47:0]          destMac_q, destMac_d;
   logic [47:0]          srcMac_q, srcMac_d;
   eth_type_t            ethType_q, ethType_d;
   logic [CNT_WIDTH-1:0] dropCount_q;
   logic [CNT_WIDTH-1:0] errorCount_q;

   logic                 matchHit;
   logic [SEL_W-1:0]     matchSel;
   logic [NUM_PORTS-1:0] selMask;
   logic                 hdrFire;
   logic                 lastFire;
   logic                 dropInc;
   logic                 errorInc;

   eth_type_matcher #(
      .NUM_PORTS      (NUM_PORTS),
      .SEL_W          (SEL_W),
      .ETH_TYPE_MATCH (ETH_TYPE_MATCH)
   ) uMatcher (
      .eth_type_i    (eth_header_in_if.eth_type),
      .port_enable_i (port_enable),
      .hit_o         (matchHit),
      .sel_o         (matchSel)
   );

   // Handshake qualifiers and the steering of the payload passthrough. The
   // payload input is only ever ready in PAYLOAD (following the selected
   // consumer) or DROP (always), so beats that arrive ahead of their header
   // simply wait upstream.
   always_comb begin
      selMask                  = NUM_PORTS'(1) << sel_q;
      eth_header_in_if.ready   = (state_q == IDLE);
      hdrFire                  = eth_header_in_if.valid & eth_header_in_if.ready;
      eth_payload_in_if.tready = 1'b0;
      out_tvalid               = '0;
      if (state_q == PAYLOAD) begin
         eth_payload_in_if.tready = |(out_tready & selMask);
         out_tvalid               = eth_payload_in_if.tvalid ? selMask : '0;
      end else if (state_q == DROP) begin
         eth_payload_in_if.tready = 1'b1;
      end
      lastFire = eth_payload_in_if.tvalid & eth_payload_in_if.tready & eth_payload_in_if.tlast;
      dropInc  = hdrFire & ~matchHit;
      errorInc = (state_q == PAYLOAD) & lastFire & eth_payload_in_if.tuser[0];
   end

   // Next-state logic. The header and the selected port are captured at
   // acceptance, so later port_enable changes cannot redirect a frame in
   // flight. The header valid is held until the selected consumer takes it.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      hdrValid_d = hdrValid_q;
      destMac_d  = destMac_q;
      srcMac_d   = srcMac_q;
      ethType_d  = ethType_q;
      unique case (state_q)
         IDLE: begin
            if (hdrFire) begin
               destMac_d = eth_header_in_if.dest_mac;
               srcMac_d  = eth_header_in_if.src_mac;
               ethType_d = eth_header_in_if.eth_type;
               sel_d     = matchSel;
               if (matchHit) begin
                  state_d    = HDR;
                  hdrValid_d = NUM_PORTS'(1) << matchSel;
               end else begin
                  state_d = DROP;
               end
            end
         end
         HDR: begin
            if (|(hdrValid_q & out_hdr_ready)) begin
               hdrValid_d = '0;
               state_d    = PAYLOAD;
            end
         end
         PAYLOAD, DROP: begin
            if (lastFire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state, header registers and statistics counters. Counters stop at
   // all-ones instead of wrapping so a saturated value is never mistaken for
   // a small one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         hdrValid_q   <= '0;
         destMac_q    <= '0;
         srcMac_q     <= '0;
         ethType_q    <= '0;
         dropCount_q  <= '0;
         errorCount_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         hdrValid_q <= hdrValid_d;
         destMac_q  <= destMac_d;
         srcMac_q   <= srcMac_d;
         ethType_q  <= ethType_d;
         if (dropInc && !(&dropCount_q)) begin
            dropCount_q <= dropCount_q + CNT_WIDTH'(1);
         end
         if (errorInc && !(&errorCount_q)) begin
            errorCount_q <= errorCount_q + CNT_WIDTH'(1);
         end
      end
   end

`ifdef ETH_RX_DISPATCH_STATS_EN
   logic [CNT_WIDTH-1:0] frameCount_q [NUM_PORTS];

   // Per-port forwarded-frame counters, stepped on each tlast handshake that
   // goes out on that port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            frameCount_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if ((state_q == PAYLOAD) && lastFire && (sel_q == SEL_W'(i))
                && !(&frameCount_q[i])) begin
               frameCount_q[i] <= frameCount_q[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign port_frame_count = frameCount_q;
`endif

   // Output mapping: header fields and valids come straight from registers,
   // payload sideband is a plain passthrough shared by every port.
   assign out_hdr_valid = hdrValid_q;
   assign out_dest_mac  = destMac_q;
   assign out_src_mac   = srcMac_q;
   assign out_eth_type  = ethType_q;
   assign out_tdata     = eth_payload_in_if.tdata;
   assign out_tlast     = eth_payload_in_if.tlast;
   assign out_tuser     = eth_payload_in_if.tuser[0];
   assign drop_count    = dropCount_q;
   assign error_count   = errorCount_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_eth_rx_type_dispatch.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_type_dispatch
// Self-checking bench for eth_rx_type_dispatch: a table of directed frames
// plus hand-written sequences for back-to-back frames, reset mid-frame and
// counter saturation. Counters are built 4 bits wide so saturation is
// reachable. With ETH_RX_DISPATCH_STATS_EN defined, per-port frame counts
// are checked as well.
// ---------------------------------------------------------------------------
module tb_eth_rx_type_dispatch;
   import eth_rx_dispatch_pkg::*;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   typedef struct {
      eth_type_t  ethType;
      logic [1:0] portEnable;
      int         len;
      logic       lastUser;
      logic       toggleReady;
      logic       expHit;
      int         expPort;
   } frame_vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       portEnable;
   logic [1:0]       outHdrValid;
   logic [1:0]       outHdrReady;
   logic [47:0]      outDestMac;
   logic [47:0]      outSrcMac;
   logic [15:0]      outEthType;
   logic [7:0]       outTdata;
   logic [1:0]       outTvalid;
   logic [1:0]       outTready;
   logic             outTlast;
   logic             outTuser;
   logic [CNT_W-1:0] dropCount;
   logic [CNT_W-1:0] errorCount;
   logic             busy;
`ifdef ETH_RX_DISPATCH_STATS_EN
   logic [CNT_W-1:0] portFrameCount [2];
`endif

   int testsRun  = 0;
   int failCount = 0;
   int expDrops  = 0;
   int expErrors = 0;

   ETH_HEADER_IF hdrIf ();
   AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) axisIf ();

   eth_rx_type_dispatch #(
      .NUM_PORTS (2),
      .CNT_WIDTH (CNT_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .eth_header_in_if  (hdrIf),
      .eth_payload_in_if (axisIf),
      .port_enable       (portEnable),
      .out_hdr_valid     (outHdrValid),
      .out_hdr_ready     (outHdrReady),
      .out_dest_mac      (outDestMac),
      .out_src_mac       (outSrcMac),
      .out_eth_type      (outEthType),
      .out_tdata         (outTdata),
      .out_tvalid        (outTvalid),
      .out_tready        (outTready),
      .out_tlast         (outTlast),
      .out_tuser         (outTuser),
      .drop_count        (dropCount),
      .error_count       (errorCount),
      .busy              (busy)
`ifdef ETH_RX_DISPATCH_STATS_EN
      ,
      .port_frame_count  (portFrameCount)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] beatData(input int len, input int beat);
      return 8'(8'hA0 + len * 16 + beat);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic driveBeat(input int len, input int beat, input logic lastUser);
      axisIf.tvalid = 1'b1;
      axisIf.tdata  = beatData(len, beat);
      axisIf.tlast  = (beat == len - 1);
      axisIf.tuser  = (beat == len - 1) && lastUser;
   endtask

   task automatic idleInputs();
      hdrIf.valid   = 1'b0;
      axisIf.tvalid = 1'b0;
      axisIf.tlast  = 1'b0;
      axisIf.tuser  = 1'b0;
      outHdrReady   = 2'b00;
      outTready     = 2'b11;
   endtask

   // Sends one complete frame and checks routing, header latency, payload
   // integrity and counters. Called at posedge+1 with the DUT idle.
   task automatic applyStimulus(input frame_vec_t v);
      logic [1:0] mask;
      int         beat;
      int         cyc;
      logic       done;
      logic       took;
      mask = v.expHit ? (2'b01 << v.expPort) : 2'b00;

      hdrIf.valid    = 1'b1;
      hdrIf.eth_type = v.ethType;
      hdrIf.dest_mac = {32'h0200_0000, v.ethType};
      hdrIf.src_mac  = {32'h0A0B_0C0D, 16'(v.len)};
      portEnable     = v.portEnable;
      outHdrReady    = 2'b00;
      outTready      = 2'b11;
      driveBeat(v.len, 0, v.lastUser);

      @(negedge clk);
      checkOutput("idle_hdr_ready", 64'(hdrIf.ready), 64'd1);
      checkOutput("idle_payload_stalled", 64'(axisIf.tready), 64'd0);

      @(posedge clk);
      #1;
      hdrIf.valid = 1'b0;
      portEnable  = ~v.portEnable;
      if (!v.expHit && expDrops < CNT_MAX) expDrops++;

      beat = 0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 64) begin
         @(negedge clk);
         if (cyc == 0) begin
            checkOutput("hdr_valid_after_accept", 64'(outHdrValid), 64'(mask));
            checkOutput("busy_in_frame", 64'(busy), 64'd1);
            checkOutput("drop_count_at_accept", 64'(dropCount), 64'(expDrops));
            checkOutput("payload_ready_first", 64'(axisIf.tready), v.expHit ? 64'd0 : 64'd1);
            if (v.expHit) begin
               checkOutput("out_eth_type", 64'(outEthType), 64'(v.ethType));
               checkOutput("out_dest_mac", 64'(outDestMac), {16'h0, 32'h0200_0000, v.ethType});
               checkOutput("out_src_mac", 64'(outSrcMac), {16'h0, 32'h0A0B_0C0D, 16'(v.len)});
            end
         end
         if (cyc == 1 && v.expHit) begin
            checkOutput("hdr_valid_held", 64'(outHdrValid), 64'(mask));
         end
         if (cyc >= 2 && v.expHit) begin
            checkOutput("tready_follows_port", 64'(axisIf.tready), 64'(outTready[v.expPort]));
         end
         took = axisIf.tvalid && axisIf.tready;
         if (took) begin
            checkOutput("out_tvalid_steer", 64'(outTvalid), 64'(mask));
            if (v.expHit) begin
               checkOutput("out_tdata", 64'(outTdata), 64'(beatData(v.len, beat)));
               checkOutput("out_tlast", 64'(outTlast), 64'(beat == v.len - 1));
            end
            if (beat == v.len - 1) done = 1'b1;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) outHdrReady = 2'b11;
         if (took) begin
            beat++;
            if (!done) driveBeat(v.len, beat, v.lastUser);
         end
         if (v.toggleReady && cyc >= 3) outTready = ~outTready;
      end
      if (!done) checkOutput("frame_timeout", 64'(beat), 64'(v.len));
      checkOutput("beat_count", 64'(beat), 64'(v.len));
      if (v.expHit && v.lastUser && expErrors < CNT_MAX) expErrors++;
      idleInputs();

      @(negedge clk);
      checkOutput("busy_after_frame", 64'(busy), 64'd0);
      checkOutput("hdr_valid_after_frame", 64'(outHdrValid), 64'd0);
      checkOutput("drop_count_after_frame", 64'(dropCount), 64'(expDrops));
      checkOutput("error_count_after_frame", 64'(errorCount), 64'(expErrors));
      @(posedge clk);
      #1;
   endtask

   frame_vec_t vecs [7];
   frame_vec_t arpVec;
   frame_vec_t ipv6Vec;

   initial begin
      vecs[0] = '{ethType: 16'h0806, portEnable: 2'b11, len: 4, lastUser: 1'b0, toggleReady: 1'b0, expHit: 1'b1, expPort: 0};
      vecs[1] = '{ethType: 16'h0800, portEnable: 2'b11, len: 3, lastUser: 1'b0, toggleReady: 1'b1, expHit: 1'b1, expPort: 1};
      vecs[2] = '{ethType: 16'h86DD, portEnable: 2'b11, len: 5, lastUser: 1'b0, toggleReady: 1'b0, expHit: 1'b0, expPort: 0};
      vecs[3] = '{ethType: 16'h0800, portEnable: 2'b01, len: 2, lastUser: 1'b0, toggleReady: 1'b0, expHit: 1'b0, expPort: 0};
      vecs[4] = '{ethType: 16'h0806, portEnable: 2'b01, len: 1, lastUser: 1'b0, toggleReady: 1'b0, expHit: 1'b1, expPort: 0};
      vecs[5] = '{ethType: 16'h0800, portEnable: 2'b11, len: 2, lastUser: 1'b1, toggleReady: 1'b0, expHit: 1'b1, expPort: 1};
      vecs[6] = '{ethType: 16'h0806, portEnable: 2'b10, len: 1, lastUser: 1'b0, toggleReady: 1'b0, expHit: 1'b0, expPort: 0};
      arpVec  = '{ethType: 16'h0806, portEnable: 2'b11, len: 2, lastUser: 1'b0, toggleReady: 1'b0, expHit: 1'b1, expPort: 0};
      ipv6Vec = '{ethType: 16'h86DD, portEnable: 2'b11, len: 1, lastUser: 1'b0, toggleReady: 1'b0, expHit: 1'b0, expPort: 0};

      reset          = 1'b0;
      portEnable     = 2'b11;
      hdrIf.eth_type = '0;
      hdrIf.dest_mac = '0;
      hdrIf.src_mac  = '0;
      axisIf.tdata   = '0;
      idleInputs();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      @(negedge clk);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_hdr_valid", 64'(outHdrValid), 64'd0);
      checkOutput("reset_tvalid", 64'(outTvalid), 64'd0);
      checkOutput("reset_drop_count", 64'(dropCount), 64'd0);
      checkOutput("reset_error_count", 64'(errorCount), 64'd0);
      checkOutput("reset_dest_mac", 64'(outDestMac), 64'd0);
      checkOutput("reset_hdr_ready", 64'(hdrIf.ready), 64'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      // Back-to-back single-byte frames: the second header must be taken
      // in the cycle right after the first tlast beat.
      portEnable     = 2'b11;
      outHdrReady    = 2'b11;
      outTready      = 2'b11;
      hdrIf.valid    = 1'b1;
      hdrIf.eth_type = 16'h0806;
      axisIf.tvalid  = 1'b1;
      axisIf.tdata   = 8'h5A;
      axisIf.tlast   = 1'b1;
      axisIf.tuser   = 1'b0;
      @(posedge clk);
      #1;
      hdrIf.eth_type = 16'h0800;
      @(negedge clk);
      checkOutput("b2b_first_hdr_valid", 64'(outHdrValid), 64'd1);
      checkOutput("b2b_hdr_ready_low", 64'(hdrIf.ready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("b2b_first_tvalid", 64'(outTvalid), 64'd1);
      checkOutput("b2b_first_tdata", 64'(outTdata), 64'h5A);
      @(posedge clk);
      #1;
      axisIf.tdata = 8'h5B;
      @(negedge clk);
      checkOutput("b2b_zero_bubble_ready", 64'(hdrIf.ready), 64'd1);
      checkOutput("b2b_idle_between", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      hdrIf.valid = 1'b0;
      @(negedge clk);
      checkOutput("b2b_second_hdr_valid", 64'(outHdrValid), 64'd2);
      checkOutput("b2b_second_eth_type", 64'(outEthType), 64'h0800);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("b2b_second_tvalid", 64'(outTvalid), 64'd2);
      checkOutput("b2b_second_tdata", 64'(outTdata), 64'h5B);
      @(posedge clk);
      #1;
      idleInputs();
      @(negedge clk);
      checkOutput("b2b_busy_after", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      // Reset asserted while a frame is stalled in PAYLOAD.
      outHdrReady    = 2'b11;
      outTready      = 2'b00;
      hdrIf.valid    = 1'b1;
      hdrIf.eth_type = 16'h0800;
      driveBeat(4, 0, 1'b0);
      @(posedge clk);
      #1;
      hdrIf.valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rst_mid_pre_tvalid", 64'(outTvalid), 64'd2);
      checkOutput("rst_mid_pre_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_tvalid", 64'(outTvalid), 64'd0);
      checkOutput("rst_mid_hdr_valid", 64'(outHdrValid), 64'd0);
      checkOutput("rst_mid_busy", 64'(busy), 64'd0);
      checkOutput("rst_mid_drop_count", 64'(dropCount), 64'd0);
      checkOutput("rst_mid_error_count", 64'(errorCount), 64'd0);
      checkOutput("rst_mid_eth_type", 64'(outEthType), 64'd0);
      checkOutput("rst_mid_payload_ready", 64'(axisIf.tready), 64'd0);
      expDrops  = 0;
      expErrors = 0;
      @(posedge clk);
      #1;
      idleInputs();

      for (int i = 0; i < 3; i++) begin
         applyStimulus(arpVec);
      end
`ifdef ETH_RX_DISPATCH_STATS_EN
      @(negedge clk);
      checkOutput("port0_frame_count", 64'(portFrameCount[0]), 64'd3);
      checkOutput("port1_frame_count", 64'(portFrameCount[1]), 64'd0);
      @(posedge clk);
      #1;
`endif

      // Drop more frames than the counter can hold; it must stick at max.
      for (int i = 0; i < CNT_MAX + 2; i++) begin
         applyStimulus(ipv6Vec);
      end
      @(negedge clk);
      checkOutput("drop_count_saturated", 64'(dropCount), 64'(CNT_MAX));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
